// File: rtl/jk_bank_sequencer_if.sv
// Command/bank bus for jk_bank_sequencer.
//  master : command source and JK bank (drives cmd_*, abort, q_in)
//  slave  : sequencer (drives cmd_ready, j_out, k_out, busy, done, err, result)
interface jk_bank_sequencer_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic [N-1:0]  q_in;
  logic [N-1:0]  j_out;
  logic [N-1:0]  k_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [N-1:0]  result;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, abort, q_in,
    output cmd_ready, j_out, k_out, busy, done, err, result
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, abort, q_in,
    input  cmd_ready, j_out, k_out, busy, done, err, result
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller for an external bank of N JK flip-flops.
// Accepts one command, drives j/k for the required number of cycles, then
// checks the bank output against the expected value and reports done/err.
// Ports:
//  clk  : clock, rising edge (bank shares it)
//  rst  : asynchronous, active-low reset
//  bus  : jk_bank_sequencer_if.slave (command handshake, bank j/k/q, status)
module jk_bank_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  jk_bank_sequencer_if.slave  bus
);

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  q_start_q, q_start_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] rem_init_q, rem_init_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [N-1:0]  result_q, result_d;

  logic [N-1:0]  expected_c;
  logic [CW-1:0] count_sum_c;
  logic [CW-1:0] accept_cnt_c;
  logic [N-1:0]  j_c, k_c;
  logic          carry_c;

  // State and command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      data_q     <= '0;
      q_start_q  <= '0;
      rem_q      <= '0;
      rem_init_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      q_start_q  <= q_start_d;
      rem_q      <= rem_d;
      rem_init_q <= rem_init_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
    end
  end

  // Cycle count latched at accept: zero means one, single-shot ops always one
  always_comb begin
    accept_cnt_c = (bus.cmd_count == '0) ? CW'(1) : bus.cmd_count;
    if (bus.cmd_op == OP_CLEAR || bus.cmd_op == OP_SET || bus.cmd_op == OP_LOAD) begin
      accept_cnt_c = CW'(1);
    end
  end

  // Expected bank value after rem_init updates
  always_comb begin
    count_sum_c = CW'(q_start_q) + rem_init_q;
    expected_c  = q_start_q;
    case (op_q)
      OP_HOLD:   expected_c = q_start_q;
      OP_CLEAR:  expected_c = '0;
      OP_SET:    expected_c = '1;
      OP_TOGGLE: expected_c = rem_init_q[0] ? (q_start_q ^ data_q) : q_start_q;
      OP_LOAD:   expected_c = data_q;
      OP_COUNT:  expected_c = count_sum_c[N-1:0];
      default:   expected_c = q_start_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    q_start_d  = q_start_q;
    rem_d      = rem_q;
    rem_init_d = rem_init_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          data_d     = bus.cmd_data;
          q_start_d  = bus.q_in;
          rem_d      = accept_cnt_c;
          rem_init_d = accept_cnt_c;
          if (bus.cmd_op > OP_COUNT) begin
            // Illegal op completes immediately without touching the bank
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!bus.abort) begin
          done_d   = 1'b1;
          err_d    = (bus.q_in != expected_c);
          result_d = bus.q_in;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bank j/k drive; only APPLY moves the bank
  always_comb begin
    j_c     = '0;
    k_c     = '0;
    carry_c = 1'b1;
    if (state_q == S_APPLY) begin
      case (op_q)
        OP_HOLD:   begin j_c = '0;      k_c = '0;       end
        OP_CLEAR:  begin j_c = '0;      k_c = '1;       end
        OP_SET:    begin j_c = '1;      k_c = '0;       end
        OP_TOGGLE: begin j_c = data_q;  k_c = data_q;   end
        OP_LOAD:   begin j_c = data_q;  k_c = ~data_q;  end
        OP_COUNT: begin
          // Ripple counter: bit i toggles when all lower bits are one
          for (int i = 0; i < int'(N); i++) begin
            j_c[i]  = carry_c;
            k_c[i]  = carry_c;
            carry_c = carry_c & bus.q_in[i];
          end
        end
        default:   begin j_c = '0;      k_c = '0;       end
      endcase
    end
  end

  assign bus.j_out     = j_c;
  assign bus.k_out     = k_c;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;

endmodule
